pwl_act_simd: RTL and testbench

//   Parametrised N-lane piecewise-linear activation unit. Each lane computes tanh or sigmoid per beat.

---
 rtl/pwl_act_simd.sv | 173 +++++++++++++++++
 tb/tb_pwl_act_simd.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_act_simd.sv
// N-lane piecewise-linear tanh/sigmoid unit: decode, multiply-add, then output/clamp stages.
// Sigmoid reuses the tanh slices as 0.5 + tanh(x/2)/2, so only one table exists.
module pwl_act_simd #(
    parameter int LANES = 2,
    parameter int W     = 16,
    parameter int FRAC  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] x_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] y_out,
    output logic [LANES-1:0]   sat_out,
    output logic               mode_out
);
    localparam int XW = W + 2;

    // Table constants are written in Q.11 and rescaled to the configured FRAC.
    function automatic logic signed [XW-1:0] q11(input int v);
        int sh;
        sh = FRAC - 11;
        if (sh >= 0) q11 = XW'(v <<< sh);
        else         q11 = XW'(v >>> (-sh));
    endfunction

    localparam logic signed [XW-1:0] BP_N3 = q11(-6144);
    localparam logic signed [XW-1:0] BP_N2 = q11(-4096);
    localparam logic signed [XW-1:0] BP_NH = q11(-1024);
    localparam logic signed [XW-1:0] BP_PH = q11(1024);
    localparam logic signed [XW-1:0] BP_P2 = q11(4096);
    localparam logic signed [XW-1:0] BP_P3 = q11(6144);
    localparam logic signed [W-1:0]  M_OUT = W'(q11(100));
    localparam logic signed [W-1:0]  M_MID = W'(q11(717));
    localparam logic signed [W-1:0]  M_CTR = W'(q11(1556));
    localparam logic signed [XW-1:0] C_OUT = q11(1720);
    localparam logic signed [XW-1:0] C_MID = q11(655);
    localparam logic signed [XW-1:0] SAT_V = q11(2038);
    localparam logic signed [XW-1:0] HALF  = q11(1024);
    localparam logic signed [XW-1:0] Y_MAX = XW'((1 <<< (W-1)) - 1);
    localparam logic signed [XW-1:0] Y_MIN = -Y_MAX - 1;

    logic                 w_adv;
    logic signed [W-1:0]  w_xd   [LANES];
    logic signed [XW-1:0] w_xe   [LANES];
    logic signed [W-1:0]  w_mul  [LANES];
    logic signed [XW-1:0] w_c    [LANES];
    logic [LANES-1:0]     w_slo, w_shi, w_sat2, w_sat3;
    logic signed [2*W-1:0] w_p   [LANES];
    logic signed [XW-1:0] w_t    [LANES];
    logic signed [XW-1:0] w_ys   [LANES];
    logic [W-1:0]         w_yo   [LANES];

    logic                 r_v1, r_v2, r_v3;
    logic                 r_mode1, r_mode2, r_mode3;
    logic signed [W-1:0]  r_xd   [LANES];
    logic signed [W-1:0]  r_mul  [LANES];
    logic signed [XW-1:0] r_c    [LANES];
    logic [LANES-1:0]     r_slo, r_shi;
    logic signed [XW-1:0] r_t    [LANES];
    logic [LANES-1:0]     r_sat2;
    logic [LANES*W-1:0]   r_y;
    logic [LANES-1:0]     r_sat3;

    // Handshake: a beat moves on in_valid & in_ready; every stage shifts together
    // whenever the output register is empty or being drained (w_adv).
    assign w_adv     = ~r_v3 | out_ready;
    assign in_ready  = w_adv & ~rst;
    assign out_valid = r_v3;
    assign y_out     = r_y;
    assign sat_out   = r_sat3;
    assign mode_out  = r_mode3;

    always_comb begin
        w_slo = '0;
        w_shi = '0;
        for (int i = 0; i < LANES; i++) begin
            w_xd[i]  = mode_in ? ($signed(x_in[i*W +: W]) >>> 1) : $signed(x_in[i*W +: W]);
            w_xe[i]  = XW'(w_xd[i]);
            w_mul[i] = '0;
            w_c[i]   = '0;
            // Each compare is "less than the next breakpoint", so ties land in the upper segment.
            if (w_xe[i] < BP_N3) begin
                w_slo[i] = 1'b1;
            end else if (w_xe[i] < BP_N2) begin
                w_mul[i] = M_OUT;
                w_c[i]   = -C_OUT;
            end else if (w_xe[i] < BP_NH) begin
                w_mul[i] = M_MID;
                w_c[i]   = -C_MID;
            end else if (w_xe[i] < BP_PH) begin
                w_mul[i] = M_CTR;
            end else if (w_xe[i] < BP_P2) begin
                w_mul[i] = M_MID;
                w_c[i]   = C_MID;
            end else if (w_xe[i] < BP_P3) begin
                w_mul[i] = M_OUT;
                w_c[i]   = C_OUT;
            end else begin
                w_shi[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sat2 = '0;
        for (int i = 0; i < LANES; i++) begin
            w_p[i]    = r_mul[i] * r_xd[i];
            w_t[i]    = r_slo[i] ? -SAT_V : (r_shi[i] ? SAT_V : XW'(w_p[i] >>> FRAC) + r_c[i]);
            w_sat2[i] = r_slo[i] | r_shi[i];
        end
    end

    always_comb begin
        w_sat3 = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ys[i] = r_mode2 ? (r_t[i] >>> 1) + HALF : r_t[i];
            w_yo[i] = w_ys[i][W-1:0];
            w_sat3[i] = r_sat2[i];
            if (w_ys[i] > Y_MAX) begin
                w_yo[i]   = Y_MAX[W-1:0];
                w_sat3[i] = 1'b1;
            end else if (w_ys[i] < Y_MIN) begin
                w_yo[i]   = Y_MIN[W-1:0];
                w_sat3[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_mode1 <= 1'b0;
            r_mode2 <= 1'b0;
            r_mode3 <= 1'b0;
            r_slo   <= '0;
            r_shi   <= '0;
            r_sat2  <= '0;
            r_sat3  <= '0;
            r_y     <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_xd[i]  <= '0;
                r_mul[i] <= '0;
                r_c[i]   <= '0;
                r_t[i]   <= '0;
            end
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_mode1 <= mode_in;
            r_mode2 <= r_mode1;
            r_mode3 <= r_mode2;
            r_slo   <= w_slo;
            r_shi   <= w_shi;
            r_sat2  <= w_sat2;
            r_sat3  <= w_sat3;
            for (int i = 0; i < LANES; i++) begin
                r_xd[i]        <= w_xd[i];
                r_mul[i]       <= w_mul[i];
                r_c[i]         <= w_c[i];
                r_t[i]         <= w_t[i];
                r_y[i*W +: W]  <= w_yo[i];
            end
        end
    end

endmodule

// File: tb/tb_pwl_act_simd.sv
// Bench for pwl_act_simd: directed table, latency, backpressure, random traffic,
// mid-stream reset and a 4-lane instance, all checked through one expected-beat queue.
module tb_pwl_act_simd;
    localparam int LANES = 2;
    localparam int W     = 16;
    localparam int FRAC  = 11;
    localparam int EW    = LANES*W + LANES + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mode_in = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [LANES*W-1:0] x_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [LANES*W-1:0] y_out;
    logic [LANES-1:0]   sat_out;
    logic               mode_out;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [63:0] x4 = '0;
    logic        out_valid4;
    logic [63:0] y4;
    logic [3:0]  sat4;
    logic        mode_out4;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] pend_exp = '0;
    logic [EW-1:0] mon_exp, mon_got;
    int beat_no = 0;
    bit rnd_done = 0;

    int bp_tab[6] = '{-6144, -4096, -1024, 1024, 4096, 6144};
    int m_tab[5]  = '{100, 717, 1556, 717, 100};
    int c_tab[5]  = '{-1720, -655, 0, 655, 1720};

    typedef struct {
        logic       md;
        int         x0, x1, y0, y1;
        logic [1:0] sat;
    } vec_t;
    vec_t vt[8];

    pwl_act_simd #(.LANES(LANES), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
        .sat_out(sat_out), .mode_out(mode_out)
    );

    pwl_act_simd #(.LANES(4), .W(16), .FRAC(11)) dut4 (
        .clk(clk), .rst(rst), .mode_in(1'b0), .in_valid(in_valid4), .in_ready(in_ready4),
        .x_in(x4), .out_valid(out_valid4), .out_ready(1'b1), .y_out(y4),
        .sat_out(sat4), .mode_out(mode_out4)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // reference model: tanh slices from the breakpoint table, sigmoid = 0.5 + tanh(x/2)/2
    function automatic void ref_lane(input int x, input bit md, output int y, output bit s);
        int xd, seg, t;
        longint p;
        xd = md ? (x >>> 1) : x;
        seg = 0;
        for (int k = 0; k < 6; k++) if (xd >= bp_tab[k]) seg = k + 1;
        s = 1'b0;
        if (seg == 0) begin
            t = -2038; s = 1'b1;
        end else if (seg == 6) begin
            t = 2038; s = 1'b1;
        end else begin
            p = longint'(m_tab[seg-1]) * longint'(xd);
            t = int'(p >>> 11) + c_tab[seg-1];
        end
        y = md ? (t >>> 1) + 1024 : t;
        if (y > 32767) begin y = 32767; s = 1'b1; end
        if (y < -32768) begin y = -32768; s = 1'b1; end
    endfunction

    function automatic logic [EW-1:0] model_beat(input logic [LANES*W-1:0] x, input logic md);
        logic [EW-1:0] r;
        int y;
        bit s;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            ref_lane(int'($signed(x[i*W +: W])), md, y, s);
            r[i*W +: W]     = W'(y);
            r[LANES*W + i]  = s;
        end
        r[EW-1] = md;
        return r;
    endfunction

    function automatic logic [LANES*W-1:0] rand_x();
        logic [LANES*W-1:0] r;
        int v;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 65535)) - 32768;
            else                           v = int'($urandom_range(0, 16383)) - 8192;
            r[i*W +: W] = W'(v);
        end
        return r;
    endfunction

    // driver tasks (called at posedge + 1)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [LANES*W-1:0] x, input logic md, input logic [EW-1:0] ex);
        int g;
        g = 0;
        pend_exp = ex;
        x_in     = x;
        mode_in  = md;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            tick();
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // scoreboard: push on accepted beats, compare on delivered beats
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(pend_exp);
            if (out_valid && out_ready) begin
                beat_no++;
                checks++;
                mon_got = {mode_out, sat_out, y_out};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat %0d: unexpected output %h, required none", beat_no, mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL beat %0d: got {mode,sat,y}=%h expected %h", beat_no, mon_got, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        logic [LANES*W-1:0] x;
        logic md;
        logic [EW-1:0] snap;
        int n;

        vt[0] = '{1'b0,    512,  -2048,  389, -1372, 2'b00};
        vt[1] = '{1'b0,   5120,  -8192, 1970, -2038, 2'b10};
        vt[2] = '{1'b1,      0,  16384, 1024,  2043, 2'b10};
        vt[3] = '{1'b0,  -1024,   1024, -778,  1013, 2'b00};
        vt[4] = '{1'b0,   6144,      0, 2038,     0, 2'b01};
        vt[5] = '{1'b1, -16384,   2048,    5,  1530, 2'b01};
        vt[6] = '{1'b0,  -6145,  -6144, -2038, -2020, 2'b01};
        vt[7] = '{1'b0,  -4096,   4096, -2089, 1920, 2'b00};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_y_out", 80'(y_out), 80'(0));
        chk("rst_sat_out", 80'(sat_out), 80'(0));
        chk("rst_mode_out", 80'(mode_out), 80'(0));
        chk("rst_in_ready", 80'(in_ready), 80'(0));
        chk("rst_out_valid4", 80'(out_valid4), 80'(0));
        tick();
        rst = 1'b0;
        tick();

        // directed table
        for (int k = 0; k < 8; k++) begin
            x = {W'(vt[k].x1), W'(vt[k].x0)};
            drive(x, vt[k].md, {vt[k].md, vt[k].sat, W'(vt[k].y1), W'(vt[k].y0)});
        end
        drain();

        // latency from acceptance to out_valid
        x = {16'd0, 16'd512};
        pend_exp = model_beat(x, 1'b0);
        x_in = x; mode_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 80'(in_ready), 80'(1));
        tick();
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("latency", 80'(n), 80'(3));
        tick();
        drain();

        // 4-lane independence
        x4 = {16'h2000, 16'h0200, 16'h0000, 16'he000};
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("lanes4", {12'd0, sat4, y4}, {12'd0, 4'b1001, 16'h07f6, 16'h0185, 16'h0000, 16'hf80a});
        tick();

        // backpressure: 10 alternating-mode beats with a 5-cycle stall mid-stream
        fork
            begin : bp_drv
                logic [LANES*W-1:0] bx;
                for (int k = 0; k < 10; k++) begin
                    bx = rand_x();
                    drive(bx, k[0], model_beat(bx, k[0]));
                end
            end
            begin : bp_stall
                int g;
                g = 0;
                while (!out_valid && g < 50) begin
                    tick();
                    g++;
                end
                repeat (2) tick();
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    if (s == 0) snap = {mode_out, sat_out, y_out};
                    chk("stall_in_ready", 80'({out_valid, in_ready}), 80'(2'b10));
                    if (s > 0) chk("stall_hold", 80'({mode_out, sat_out, y_out}), 80'(snap));
                end
                tick();
                out_ready = 1'b1;
            end
        join
        drain();

        // random traffic with random downstream stalls
        rnd_done = 0;
        fork
            begin : rnd_drv
                logic [LANES*W-1:0] rx;
                logic rm;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    rx = rand_x();
                    rm = 1'($urandom_range(0, 1));
                    drive(rx, rm, model_beat(rx, rm));
                end
                rnd_done = 1;
            end
            begin : rnd_rdy
                int g;
                g = 0;
                while (!rnd_done && g < 3000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                    g++;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            x = rand_x();
            drive(x, 1'(k), model_beat(x, 1'(k)));
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 80'(out_valid), 80'(0));
        chk("midrst_y_out", 80'(y_out), 80'(0));
        tick();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("midrst_no_ghost", 80'(n), 80'(0));
        tick();
        x = {16'hf000, 16'h0400};
        drive(x, 1'b1, model_beat(x, 1'b1));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
